// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, single-outstanding imem fetch, instruction FIFO to decode with redirect flush
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] ONE = 1;
  typedef enum logic [1:0] {ISSUE, WAIT, DROP} state_t;
  state_t state, state_nx;
  logic [31:0] pc, req_pc;
  logic [31:0] buf_pc [DEPTH];
  logic [31:0] buf_data [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic fire, push, pop;
  always_ff @(posedge clk)
    if (reset) state <= ISSUE;
    else state <= state_nx;
  // a redirect discards whatever response is due: coincident ones immediately, later ones via DROP
  always_comb begin
    state_nx = state;
    if (redirect_valid) state_nx = (state == ISSUE || imem_resp_valid) ? ISSUE : DROP;
    else if (state == ISSUE) state_nx = fire ? WAIT : ISSUE;
    else state_nx = imem_resp_valid ? ISSUE : state;
  end
  always_comb begin
    imem_req_valid = state == ISSUE && !reset && !redirect_valid && count < FULL;
    fire = imem_req_valid && imem_req_ready;
    push = state == WAIT && imem_resp_valid && !redirect_valid;
    inst_valid = count != '0;
    pop = inst_valid && inst_ready;
    inst_data = inst_valid ? buf_data[rptr] : '0;
    inst_pc = inst_valid ? buf_pc[rptr] : '0;
  end
  assign imem_req_addr = pc;
  always_ff @(posedge clk)
    if (reset) begin
      pc <= RESET_PC;
      req_pc <= '0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~32'd3;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (fire) begin
        pc <= pc + 32'd4;
        req_pc <= pc;
      end
      if (push) wptr <= wptr + ONE;
      if (pop) rptr <= rptr + ONE;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  always_ff @(posedge clk)
    if (!reset && push) begin
      buf_pc[wptr] <= req_pc;
      buf_data[wptr] <= imem_resp_data;
    end
endmodule
